// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low hex patterns {a..g}, blank code,
// capture FSM state encodings and anode helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic an_one_low(input logic [3:0] an);
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] an_idx(input logic [3:0] an);
    case (an)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Multiplexed display lines (driver side) plus the decoded capture results.
// SEG7_DP_CAPTURE_EN adds the dp_mask result.
interface seg7_scan_capture_if;
  logic        an3, an2, an1, an0;
  logic        led_a, led_b, led_c, led_d, led_e, led_f, led_g;
  logic        dp;
  logic        capture_stb;
  logic [1:0]  cur_idx;
  logic [3:0]  cur_digit;
  logic        frame_valid;
  logic [15:0] digit_val;
  logic [3:0]  blank_mask;
  logic        seg_err;
  logic        anode_err;
`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0]  dp_mask;
`endif

  modport master (
    output an3, an2, an1, an0,
    output led_a, led_b, led_c, led_d, led_e, led_f, led_g, dp,
    input  capture_stb, cur_idx, cur_digit, frame_valid,
    input  digit_val, blank_mask, seg_err, anode_err
`ifdef SEG7_DP_CAPTURE_EN
    , input dp_mask
`endif
  );

  modport slave (
    input  an3, an2, an1, an0,
    input  led_a, led_b, led_c, led_d, led_e, led_f, led_g, dp,
    output capture_stb, cur_idx, cur_digit, frame_valid,
    output digit_val, blank_mask, seg_err, anode_err
`ifdef SEG7_DP_CAPTURE_EN
    , output dp_mask
`endif
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational active-low 7-seg pattern to nibble decoder using the shared table.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Scanned 4-digit display receiver: settles, decodes and frames the digits.
// Optional SEG7_DP_CAPTURE_EN also compares and captures the decimal point.
//
// state      | meaning
// ST_IDLE    | scan gap or no valid anode; waiting for a digit
// ST_SETTLE  | valid digit latched, counting identical cycles
// ST_HOLD    | digit sampled; waiting for the lines to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic           clk,
  input logic           reset,
  seg7_scan_capture_if.slave bus
);

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

  logic [3:0] an;
  logic [6:0] seg;
  assign an  = {bus.an3, bus.an2, bus.an1, bus.an0};
  assign seg = {bus.led_a, bus.led_b, bus.led_c, bus.led_d, bus.led_e, bus.led_f, bus.led_g};

`ifdef SEG7_DP_CAPTURE_EN
  localparam int KEY_W = 12;
  logic [KEY_W-1:0] key_now;
  assign key_now = {an, seg, bus.dp};
`else
  localparam int KEY_W = 11;
  logic [KEY_W-1:0] key_now;
  assign key_now = {an, seg};
`endif

  state_t           state;
  logic [7:0]       cnt;
  logic [KEY_W-1:0] key_lat;
  logic [3:0]       seen;
  logic [3:0]       digit_r [4];
  logic [3:0]       blank_r;

  logic        capture_stb, frame_valid, seg_err, anode_err;
  logic [1:0]  cur_idx;
  logic [3:0]  cur_digit, blank_mask;
  logic [15:0] digit_val;

  logic       dec_legal, dec_blank;
  logic [3:0] dec_nibble;

  seg7_decode u_decode (
    .seg    (seg),
    .legal  (dec_legal),
    .blank  (dec_blank),
    .nibble (dec_nibble)
  );

  // Any change from the latched lines is handled exactly as if seen from IDLE.
  logic       an_ok, an_bad, fresh, do_sample, cap_ok;
  logic [1:0] idx;
  logic [7:0] cnt_nxt;
  logic [3:0] cap_set;

  always_comb begin
    an_ok     = an_one_low(an);
    an_bad    = !an_ok && (an != 4'hF);
    idx       = an_idx(an);
    fresh     = (state == ST_IDLE) || (key_now != key_lat);
    cnt_nxt   = fresh ? 8'd1 : cnt + 8'd1;
    do_sample = an_ok && (fresh || state == ST_SETTLE) && (cnt_nxt == SETTLE_N);
    cap_ok    = do_sample && (dec_legal || dec_blank);
    cap_set   = cap_ok ? (4'b0001 << idx) : 4'b0000;
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0] dp_r, dp_mask;
  assign bus.dp_mask = dp_mask;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      key_lat     <= '0;
      seen        <= 4'b0000;
      digit_r     <= '{default: 4'h0};
      blank_r     <= 4'b0000;
      capture_stb <= 1'b0;
      cur_idx     <= 2'd0;
      cur_digit   <= 4'h0;
      frame_valid <= 1'b0;
      digit_val   <= 16'h0000;
      blank_mask  <= 4'b0000;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      dp_r        <= 4'b0000;
      dp_mask     <= 4'b0000;
`endif
    end else begin
      capture_stb <= cap_ok;
      seg_err     <= do_sample && !(dec_legal || dec_blank);
      anode_err   <= fresh && an_bad;
      frame_valid <= (seen == 4'hF);

      if (fresh) begin
        if (an_ok) begin
          key_lat <= key_now;
          cnt     <= cnt_nxt;
          state   <= do_sample ? ST_HOLD : ST_SETTLE;
        end else begin
          cnt     <= 8'd0;
          state   <= ST_IDLE;
        end
      end else if (state == ST_SETTLE) begin
        cnt <= cnt_nxt;
        if (do_sample) state <= ST_HOLD;
      end

      if (cap_ok) begin
        cur_idx      <= idx;
        cur_digit    <= dec_nibble;
        digit_r[idx] <= dec_nibble;
        blank_r[idx] <= dec_blank;
`ifdef SEG7_DP_CAPTURE_EN
        dp_r[idx]    <= ~bus.dp;
`endif
      end

      // A capture landing on the launch cycle seeds the next frame.
      if (seen == 4'hF) begin
        seen       <= cap_set;
        digit_val  <= {digit_r[3], digit_r[2], digit_r[1], digit_r[0]};
        blank_mask <= blank_r;
`ifdef SEG7_DP_CAPTURE_EN
        dp_mask    <= dp_r;
`endif
      end else begin
        seen <= seen | cap_set;
      end
    end
  end

  assign bus.capture_stb = capture_stb;
  assign bus.cur_idx     = cur_idx;
  assign bus.cur_digit   = cur_digit;
  assign bus.frame_valid = frame_valid;
  assign bus.digit_val   = digit_val;
  assign bus.blank_mask  = blank_mask;
  assign bus.seg_err     = seg_err;
  assign bus.anode_err   = anode_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: directed scans push expected
// captures/frames/errors with their cycle; a monitor pops and compares.
module tb_seg7_scan_capture;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_scan_capture_if bus ();

  seg7_scan_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [1:0] idx; logic [3:0] digit; int cyc; } cap_t;
  typedef struct { logic [15:0] val; logic [3:0] mask; int cyc; } frm_t;

  cap_t cap_q [$];
  frm_t frm_q [$];
  int   segerr_q [$];
  int   anerr_q [$];

  function automatic logic [1:0] idx_of(input logic [3:0] a);
    case (a)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic set_lines(input logic [3:0] a, input logic [6:0] s);
    {bus.an3, bus.an2, bus.an1, bus.an0} = a;
    {bus.led_a, bus.led_b, bus.led_c, bus.led_d, bus.led_e, bus.led_f, bus.led_g} = s;
    bus.dp = 1'b1;
  endtask

  // kind: 0 nothing, 1 capture of nib, 2 seg_err, 3 anode_err
  task automatic put(input logic [3:0] a, input logic [6:0] s, input int n, input int kind,
                     input logic [3:0] nib, input bit fr, input logic [15:0] fval,
                     input logic [3:0] fmask);
    cap_t c;
    frm_t f;
    @(negedge clk);
    set_lines(a, s);
    case (kind)
      1: begin
        c.idx = idx_of(a); c.digit = nib; c.cyc = cyc + SETTLE;
        cap_q.push_back(c);
      end
      2: segerr_q.push_back(cyc + SETTLE);
      3: anerr_q.push_back(cyc + 1);
      default: ;
    endcase
    if (fr) begin
      f.val = fval; f.mask = fmask; f.cyc = cyc + SETTLE + 1;
      frm_q.push_back(f);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic gap(input int n);
    put(4'hF, 7'h7F, n, 0, 4'h0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic dig(input logic [3:0] a, input logic [6:0] s, input logic [3:0] nib);
    put(a, s, 6, 1, nib, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor
  initial begin
    cap_t e;
    frm_t f;
    int   t;
    forever begin
      @(negedge clk);
      if (bus.capture_stb === 1'b1) begin
        checks++;
        if (cap_q.size() == 0) begin
          errors++;
          $display("FAIL capture: unexpected idx=%0d digit=%h at cycle %0d", bus.cur_idx, bus.cur_digit, cyc);
        end else begin
          e = cap_q.pop_front();
          if (bus.cur_idx !== e.idx || bus.cur_digit !== e.digit || cyc != e.cyc) begin
            errors++;
            $display("FAIL capture: got idx=%0d digit=%h cycle %0d expected idx=%0d digit=%h cycle %0d",
                     bus.cur_idx, bus.cur_digit, cyc, e.idx, e.digit, e.cyc);
          end
        end
      end
      if (bus.frame_valid === 1'b1) begin
        checks++;
        if (frm_q.size() == 0) begin
          errors++;
          $display("FAIL frame: unexpected val=%h mask=%b at cycle %0d", bus.digit_val, bus.blank_mask, cyc);
        end else begin
          f = frm_q.pop_front();
          if (bus.digit_val !== f.val || bus.blank_mask !== f.mask || cyc != f.cyc) begin
            errors++;
            $display("FAIL frame: got val=%h mask=%b cycle %0d expected val=%h mask=%b cycle %0d",
                     bus.digit_val, bus.blank_mask, cyc, f.val, f.mask, f.cyc);
          end
        end
      end
      if (bus.seg_err === 1'b1) begin
        checks++;
        t = (segerr_q.size() == 0) ? -1 : segerr_q.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL seg_err: seen at cycle %0d expected cycle %0d", cyc, t);
        end
      end
      if (bus.anode_err === 1'b1) begin
        checks++;
        t = (anerr_q.size() == 0) ? -1 : anerr_q.pop_front();
        if (t != cyc) begin
          errors++;
          $display("FAIL anode_err: seen at cycle %0d expected cycle %0d", cyc, t);
        end
      end
    end
  end

  // Stimulus
  initial begin
    set_lines(4'hF, 7'h7F);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_pulses", {28'h0, bus.capture_stb, bus.frame_valid, bus.seg_err, bus.anode_err}, 32'h0);
    chk("reset_cur", {26'h0, bus.cur_idx, bus.cur_digit}, 32'h0);
    chk("reset_digit_val", {16'h0, bus.digit_val}, 32'h0);
    chk("reset_blank_mask", {28'h0, bus.blank_mask}, 32'h0);
    reset = 1'b0;

    // Scan 1,2,3,4
    put(4'b1110, 7'h4F, 8, 1, 4'h1, 1'b0, 16'h0, 4'h0);
    put(4'b1101, 7'h12, 8, 1, 4'h2, 1'b0, 16'h0, 4'h0);
    put(4'b1011, 7'h06, 8, 1, 4'h3, 1'b0, 16'h0, 4'h0);
    put(4'b0111, 7'h4C, 8, 1, 4'h4, 1'b1, 16'h4321, 4'h0);
    gap(3);
    chk("frame1_digit_val", {16'h0, bus.digit_val}, 32'h4321);

    // Short-held digit then a 4-cycle digit
    put(4'b1110, 7'h24, 3, 0, 4'h0, 1'b0, 16'h0, 4'h0);
    put(4'b1110, 7'h20, 4, 1, 4'h6, 1'b0, 16'h0, 4'h0);
    gap(3);
    chk("digit_val_held", {16'h0, bus.digit_val}, 32'h4321);

    // Two anodes low
    put(4'b1010, 7'h4F, 1, 3, 4'h0, 1'b0, 16'h0, 4'h0);
    gap(3);

    // Illegal pattern on idx2, then idx1/idx3 leave frame incomplete
    put(4'b1011, 7'h7E, 6, 2, 4'h0, 1'b0, 16'h0, 4'h0);
    gap(2);
    dig(4'b1101, 7'h04, 4'h9);
    dig(4'b0111, 7'h06, 4'h3);
    gap(4);

    // Reset discards the partial frame
    @(negedge clk);
    reset = 1'b1;
    set_lines(4'hF, 7'h7F);
    repeat (2) @(negedge clk);
    chk("midreset_digit_val", {16'h0, bus.digit_val}, 32'h0);
    reset = 1'b0;
    dig(4'b1110, 7'h08, 4'hA);
    dig(4'b1101, 7'h60, 4'hB);
    dig(4'b1011, 7'h31, 4'hC);
    put(4'b0111, 7'h42, 6, 1, 4'hD, 1'b1, 16'hDCBA, 4'h0);
    gap(3);
    chk("frame2_digit_val", {16'h0, bus.digit_val}, 32'hDCBA);

    // Overwrite of idx0 and a blank digit
    dig(4'b1110, 7'h0F, 4'h7);
    dig(4'b1110, 7'h00, 4'h8);
    dig(4'b1101, 7'h7F, 4'h0);
    dig(4'b1011, 7'h38, 4'hF);
    put(4'b0111, 7'h30, 6, 1, 4'hE, 1'b1, 16'hEF08, 4'b0010);
    gap(4);
    chk("frame3_blank_mask", {28'h0, bus.blank_mask}, 32'h2);

    repeat (10) @(negedge clk);
    chk("cap_q_drained", cap_q.size(), 0);
    chk("frm_q_drained", frm_q.size(), 0);
    chk("segerr_q_drained", segerr_q.size(), 0);
    chk("anerr_q_drained", anerr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
